rib_slow_bridge: RTL and testbench
==================================

// Module: rib_slow_bridge
// PURPOSE
//  Downstream of the core data port: turns the core's same-cycle memory request (addr/wdata/req/we,
//  read data expected combinationally) into a registered valid/ready transaction for slow peripherals.
//  Drives the core's bus-hold input so the pipeline stalls until the peripheral responds or times out.
//  Requests outside the slow window pass straight through with zero added latency.
// PARAMETERS
//  SLOW_BASE   4'h3          addr[31:28] value selecting the slow window
//  TIMEOUT     16            max cycles waiting for s_ready_i before abort (1..255)
//  ERR_DATA    32'hDEAD_BEEF read data returned on timeout
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active high
//  core_addr_i  in   32  core data address (write addr when we=1, else read addr)
//  core_data_i  in   32  core write data
//  core_req_i   in   1   core access request
//  core_we_i    in   1   core write enable
//  core_data_o  out  32  read data to core
//  hold_flag_o  out  1   stall request to core control (bus hold)
//  fast_data_i  in   32  read data from fast (passthrough) bus
//  fast_req_o   out  1   passthrough request (core_req_i & ~slow hit)
//  s_valid_o    out  1   slow transaction valid
//  s_we_o       out  1   slow write enable
//  s_addr_o     out  32  slow address
//  s_wdata_o    out  32  slow write data
//  s_ready_i    in   1   slow peripheral accepts/completes transaction
//  s_rdata_i    in   32  slow read data, valid when s_valid_o & s_ready_i
//  timeout_o    out  1   sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  - hit = core_req_i & (core_addr_i[31:28]==SLOW_BASE). Non-hit: fast_req_o=core_req_i,
//    core_data_o=fast_data_i combinationally, hold_flag_o=0 (in IDLE).
//  - FSM states: IDLE, WAIT, DONE.
//    IDLE: hit -> hold_flag_o=1 combinationally same cycle; register addr/we/wdata; next WAIT.
//    WAIT: s_valid_o=1 with registered addr/we/wdata (stable until accepted); hold_flag_o=1;
//          s_ready_i=1 -> capture s_rdata_i (reads) into rdata_q, next DONE;
//          counter reaches TIMEOUT without ready -> rdata_q=ERR_DATA, timeout_o=1, next DONE.
//    DONE: hold_flag_o=0, core_data_o=rdata_q, s_valid_o=0, fast_req_o=0; next IDLE unconditionally.
//          Core still presents the same request this cycle; it must NOT relaunch.
//  - Read latency seen by core: IDLE cycle + >=1 WAIT cycle + DONE = min 3 cycles of held request.
//  - Writes: same sequence; core_data_o in DONE = 0 (ERR_DATA on timeout).
//  - Counter: 8-bit, cleared on entering WAIT, increments each WAIT cycle without ready; timeout
//    fires on the cycle count==TIMEOUT-1 with s_ready_i=0. Ready on that same cycle wins (no timeout).
//  - core_req_i dropping during WAIT (e.g. jump flush): transaction still completes on the slow
//    side (no abort of an issued valid); DONE then returns data nobody consumes.
//  - In WAIT/DONE, fast_req_o=0: a new request is not accepted until back in IDLE.
//  - Reset (any state, incl. mid-WAIT): state=IDLE, s_valid_o=0, hold_flag_o=0 after the edge,
//    rdata_q=0, counter=0, timeout_o=0, s_addr_o/s_wdata_o=0, s_we_o=0.
// TESTING
//  - Read 0x3000_0010, s_ready_i high 2 cycles after s_valid_o, s_rdata_i=0x1234_5678 -> hold high
//    4 cycles, core_data_o=0x1234_5678 in DONE with hold low, exactly one s_valid_o&s_ready_i beat.
//  - Write 0x3000_0004 data 0xA5A5_A5A5, ready immediately -> s_we_o=1, s_wdata_o=0xA5A5_A5A5,
//    hold high 2 cycles, no second write while core repeats request in DONE.
//  - Read 0x1000_0000 (fast) -> hold_flag_o=0, fast_req_o=1, core_data_o=fast_data_i same cycle.
//  - Slow read, s_ready_i never asserted, TIMEOUT=16 -> DONE after 16 WAIT cycles,
//    core_data_o=0xDEAD_BEEF, timeout_o=1 and remains 1 until rst.
//  - s_ready_i asserted exactly on WAIT cycle 16 -> real data returned, timeout_o stays 0.
//  - rst pulsed during WAIT -> next cycle IDLE, s_valid_o=0, hold_flag_o=0; following slow access
//    completes normally.

Source files
------------

// File: rtl/rib_slow_bridge.sv
// rib_slow_bridge
//   Sits between the core data port (same-cycle request, combinational read
//   data) and a slow valid/ready peripheral bus.
//
//   A request that hits the slow window is handled in three steps:
//     1. The core is stalled through hold_flag_o.
//     2. The request is registered and presented as a stable valid/ready
//        transaction on the slow bus.
//     3. The response, or ERR_DATA after a timeout, is returned in one DONE
//        cycle with the hold released.
//   Every other request passes straight to the fast bus with no added latency.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   core_addr_i/data_i    core address / write data
//   core_req_i/we_i       core request / write enable
//   core_data_o           read data to core
//   hold_flag_o           stall request to core
//   fast_data_i           fast-bus read data (passthrough)
//   fast_req_o            fast-bus request (passthrough)
//   s_valid_o/we_o        slow transaction valid / write enable
//   s_addr_o/wdata_o      slow address / write data (registered)
//   s_ready_i/rdata_i     slow accept-complete strobe / read data
//   timeout_o             sticky timeout flag, cleared only by reset
module rib_slow_bridge #(
    parameter logic [3:0]  SLOW_BASE = 4'h3,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    output logic [31:0] core_data_o,
    output logic        hold_flag_o,
    input  logic [31:0] fast_data_i,
    output logic        fast_req_o,
    output logic        s_valid_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_ready_i,
    input  logic [31:0] s_rdata_i,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        hit;

    assign hit = core_req_i && (core_addr_i[31:28] == SLOW_BASE);

    // Outputs toward the core.
    // In IDLE a hit asserts hold in the same cycle, so the core never
    // consumes the passthrough data for a slow access. WAIT and DONE block
    // the fast path, so only one transaction is in flight at a time.
    always_comb begin
        hold_flag_o = 1'b0;
        fast_req_o  = 1'b0;
        core_data_o = rdata_q;
        case (state)
            ST_IDLE: begin
                hold_flag_o = hit;
                fast_req_o  = core_req_i && !hit;
                core_data_o = fast_data_i;
            end
            ST_WAIT: hold_flag_o = 1'b1;
            default: ;
        endcase
    end

    assign s_valid_o = (state == ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            rdata_q   <= 32'd0;
            timeout_o <= 1'b0;
            s_addr_o  <= 32'd0;
            s_wdata_o <= 32'd0;
            s_we_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        s_addr_o  <= core_addr_i;
                        s_wdata_o <= core_data_i;
                        s_we_o    <= core_we_i;
                        cnt       <= 8'd0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A ready on the last counted cycle still completes normally.
                    // The transaction is never abandoned because core_req_i drops.
                    if (s_ready_i) begin
                        rdata_q <= s_we_o ? 32'd0 : s_rdata_i;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q   <= ERR_DATA;
                        timeout_o <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // The core still shows the same request in DONE. Returning to
                // IDLE without looking at it prevents a relaunch.
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_slow_bridge.sv
module tb_rib_slow_bridge;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr_i, core_data_i, fast_data_i, s_rdata_i;
    logic        core_req_i, core_we_i, s_ready_i;
    logic [31:0] core_data_o, s_addr_o, s_wdata_o;
    logic        hold_flag_o, fast_req_o, s_valid_o, s_we_o, timeout_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    rib_slow_bridge #(.SLOW_BASE(4'h3), .TIMEOUT(16), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .core_addr_i(core_addr_i), .core_data_i(core_data_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_data_o(core_data_o), .hold_flag_o(hold_flag_o),
        .fast_data_i(fast_data_i), .fast_req_o(fast_req_o),
        .s_valid_o(s_valid_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One slow access. rdy_at is the WAIT cycle (1-based) on which the
    // peripheral raises ready; 0 means it never does.
    task automatic slow_txn(input string tag, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int rdy_at, input int exp_hold);
        int hc, wc, beats;
        logic [31:0] exp_d;
        hc = 0; wc = 0; beats = 0;
        exp_d = (rdy_at == 0) ? ERR : (we ? 32'd0 : rdata);
        exp_q.push_back(exp_d);
        core_addr_i = addr; core_we_i = we; core_data_i = wdata; core_req_i = 1'b1;
        s_rdata_i = rdata; s_ready_i = 1'b0;
        #1;
        chk({tag, "_fast_req_on_hit"}, 32'(fast_req_o), 32'd0);
        while (hold_flag_o === 1'b1 && hc < 40) begin
            if (s_valid_o === 1'b1) begin
                wc++;
                s_ready_i = (wc == rdy_at);
            end else begin
                s_ready_i = 1'b0;
            end
            #1;
            if (wc == 1 && s_valid_o === 1'b1) begin
                chk({tag, "_s_addr"}, s_addr_o, addr);
                chk({tag, "_s_we"}, 32'(s_we_o), 32'(we));
                if (we) chk({tag, "_s_wdata"}, s_wdata_o, wdata);
                chk({tag, "_fast_req_wait"}, 32'(fast_req_o), 32'd0);
            end
            if (s_valid_o === 1'b1 && s_ready_i === 1'b1) beats++;
            hc++;
            tick();
        end
        s_ready_i = 1'b0;
        #1;
        // DONE cycle: core still requests, hold is low, data is presented.
        chk({tag, "_hold_cycles"}, 32'(hc), 32'(exp_hold));
        chk({tag, "_beats"}, 32'(beats), (rdy_at == 0) ? 32'd0 : 32'd1);
        chk({tag, "_done_valid"}, 32'(s_valid_o), 32'd0);
        chk({tag, "_done_fast_req"}, 32'(fast_req_o), 32'd0);
        if (exp_q.size() > 0) chk({tag, "_data"}, core_data_o, exp_q.pop_front());
        else chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        tick();
        // Back in IDLE: the request seen in DONE must not be relaunched.
        core_req_i = 1'b0;
        #1;
        chk({tag, "_no_relaunch"}, 32'(s_valid_o), 32'd0);
        chk({tag, "_idle_hold"}, 32'(hold_flag_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; core_addr_i = '0; core_data_i = '0; core_req_i = 1'b0; core_we_i = 1'b0;
        fast_data_i = 32'hCAFE_F00D; s_ready_i = 1'b0; s_rdata_i = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(s_valid_o), 32'd0);
        chk("rst_hold", 32'(hold_flag_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_addr", s_addr_o, 32'd0);
        tick();

        // Fast passthrough read.
        core_addr_i = 32'h1000_0000; core_req_i = 1'b1; core_we_i = 1'b0;
        #1;
        chk("fast_hold", 32'(hold_flag_o), 32'd0);
        chk("fast_req", 32'(fast_req_o), 32'd1);
        chk("fast_data", core_data_o, 32'hCAFE_F00D);
        fast_data_i = 32'h0BAD_F00D;
        #1;
        chk("fast_data_comb", core_data_o, 32'h0BAD_F00D);
        chk("fast_no_valid", 32'(s_valid_o), 32'd0);
        tick();
        core_req_i = 1'b0;
        tick();

        slow_txn("rd", 32'h3000_0010, 1'b0, 32'h0, 32'h1234_5678, 3, 4);
        slow_txn("wr", 32'h3000_0004, 1'b1, 32'hA5A5_A5A5, 32'h5555_0000, 1, 2);
        chk("timeout_clear", 32'(timeout_o), 32'd0);
        slow_txn("edge", 32'h3000_0020, 1'b0, 32'h0, 32'h7777_1111, 16, 17);
        chk("edge_no_timeout", 32'(timeout_o), 32'd0);
        slow_txn("tmo", 32'h3000_0030, 1'b0, 32'h0, 32'h9999_9999, 0, 17);
        chk("tmo_flag", 32'(timeout_o), 32'd1);
        slow_txn("after_tmo", 32'h3FFF_FFF0, 1'b0, 32'h0, 32'h0000_00AB, 2, 3);
        chk("tmo_sticky", 32'(timeout_o), 32'd1);

        // Reset in the middle of WAIT.
        core_addr_i = 32'h3000_0040; core_req_i = 1'b1; core_we_i = 1'b1;
        core_data_i = 32'h1111_2222;
        tick();
        chk("mid_valid", 32'(s_valid_o), 32'd1);
        rst = 1'b1; core_req_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(s_valid_o), 32'd0);
        chk("mid_rst_hold", 32'(hold_flag_o), 32'd0);
        chk("mid_rst_timeout", 32'(timeout_o), 32'd0);
        chk("mid_rst_we", 32'(s_we_o), 32'd0);
        chk("mid_rst_wdata", s_wdata_o, 32'd0);
        tick();
        slow_txn("post_rst", 32'h3000_0050, 1'b0, 32'h0, 32'hFEED_0001, 1, 2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
